mem_dados_sz: RTL

//   Single-port data memory for the processor's MEM stage. Successor to the fixed 64x32 array:

---
 rtl/mem_dados_pkg.sv | 35 +++
 rtl/mem_dados_sz_if.sv | 27 ++
 rtl/mem_dados_ld_fmt.sv | 27 ++
 rtl/mem_dados_sz.sv | 142 ++++++++++++++
 4 files changed

// File: rtl/mem_dados_pkg.sv
// Shared definitions for the MEM-stage data memory: access sizes, byte-lane
// mask and alignment helpers, and the clear-sequencer state encoding.
package mem_dados_pkg;

  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b10;
  localparam logic [1:0] SZ_ILL  = 2'b11;

  typedef enum logic {
    ST_CLEAR = 1'b0,
    ST_IDLE  = 1'b1
  } clr_state_t;

  // Byte lanes touched by an access of the given size at the given lane.
  function automatic logic [3:0] lane_mask(input logic [1:0] size, input logic [1:0] lane);
    case (size)
      SZ_BYTE: return 4'b0001 << lane;
      SZ_HALF: return 4'b0011 << lane;
      SZ_WORD: return 4'b1111;
      default: return 4'b0000;
    endcase
  endfunction

  // Illegal size, odd halfword, or non-word-aligned word.
  function automatic logic misaligned(input logic [1:0] size, input logic [1:0] lane);
    case (size)
      SZ_BYTE: return 1'b0;
      SZ_HALF: return lane[0];
      SZ_WORD: return lane != 2'b00;
      default: return 1'b1;
    endcase
  endfunction

endpackage

// File: rtl/mem_dados_sz_if.sv
// Request/response bus of the MEM-stage data memory.
interface mem_dados_sz_if #(
  parameter int unsigned ADDR_W = 32
);
  logic              req_valid;
  logic              req_ready;
  logic              mem_write;
  logic              mem_read;
  logic [1:0]        size;
  logic              is_unsigned;
  logic [ADDR_W-1:0] addr;
  logic [31:0]       wdata;
  logic [31:0]       rdata;
  logic              rvalid;
  logic              misalign_err;
  logic              range_err;

  modport master (
    output req_valid, mem_write, mem_read, size, is_unsigned, addr, wdata,
    input  req_ready, rdata, rvalid, misalign_err, range_err
  );

  modport slave (
    input  req_valid, mem_write, mem_read, size, is_unsigned, addr, wdata,
    output req_ready, rdata, rvalid, misalign_err, range_err
  );
endinterface

// File: rtl/mem_dados_ld_fmt.sv
// Load formatter: selects the addressed lanes of a word and sign/zero extends.
// Purely combinational so the write-back stage can reuse it.
module mem_dados_ld_fmt
  import mem_dados_pkg::*;
(
  input  logic [31:0] i_word,
  input  logic [1:0]  i_lane,
  input  logic [1:0]  i_size,
  input  logic        i_unsigned,
  output logic [31:0] o_data
);

  logic [31:0] w_sh;

  // Right-justify the addressed lane, then extend to 32 bits.
  always_comb begin
    w_sh   = i_word >> {i_lane, 3'b000};
    o_data = '0;
    case (i_size)
      SZ_BYTE: o_data = {{24{~i_unsigned & w_sh[7]}},  w_sh[7:0]};
      SZ_HALF: o_data = {{16{~i_unsigned & w_sh[15]}}, w_sh[15:0]};
      SZ_WORD: o_data = w_sh;
      default: o_data = '0;
    endcase
  end

endmodule

// File: rtl/mem_dados_sz.sv
// Single-port byte-addressed data memory for the MEM stage.
// Byte/half/word loads and stores, 1-cycle registered read, misalign and
// range error pulses. Optional power-on clear sequencer: MEM_DADOS_CLEAR_EN.
module mem_dados_sz
  import mem_dados_pkg::*;
#(
  parameter int unsigned       DEPTH     = 64,
  parameter int unsigned       ADDR_W    = 32,
  parameter logic [ADDR_W-1:0] BASE_ADDR = '0
)(
  input logic           clk,
  input logic           rst,
  mem_dados_sz_if.slave bus
);

  localparam int unsigned       IDX_W = $clog2(DEPTH);
  localparam logic [ADDR_W-1:0] SPAN  = ADDR_W'(4 * DEPTH);

  logic [31:0]       r_mem [DEPTH];
  logic [31:0]       r_rdata;
  logic              r_rvalid;
  logic              r_mis;
  logic              r_rng;

  logic [ADDR_W-1:0] w_off;
  logic [IDX_W-1:0]  w_idx;
  logic [1:0]        w_lane;
  logic              w_ready;
  logic              w_accept;
  logic              w_is_store;
  logic              w_is_load;
  logic              w_mis;
  logic              w_rng;
  logic [3:0]        w_mask;
  logic [31:0]       w_wdata_rep;
  logic [31:0]       w_ld_data;
  logic              w_clr_we;
  logic [IDX_W-1:0]  w_clr_idx;

  assign w_off      = bus.addr - BASE_ADDR;
  assign w_idx      = w_off[IDX_W+1:2];
  assign w_lane     = w_off[1:0];
  assign w_accept   = bus.req_valid & w_ready & (bus.mem_write | bus.mem_read);
  assign w_is_store = w_accept & bus.mem_write;
  assign w_is_load  = w_accept & bus.mem_read & ~bus.mem_write;
  assign w_mis      = misaligned(bus.size, w_lane);
  assign w_rng      = ~w_mis & (w_off >= SPAN);
  assign w_mask     = lane_mask(bus.size, w_lane);

  // Replicate store data across lanes so the lane mask alone picks the target.
  always_comb begin
    w_wdata_rep = bus.wdata;
    case (bus.size)
      SZ_BYTE: w_wdata_rep = {4{bus.wdata[7:0]}};
      SZ_HALF: w_wdata_rep = {2{bus.wdata[15:0]}};
      default: ;
    endcase
  end

  mem_dados_ld_fmt u_ld_fmt (
    .i_word     (r_mem[w_idx]),
    .i_lane     (w_lane),
    .i_size     (bus.size),
    .i_unsigned (bus.is_unsigned),
    .o_data     (w_ld_data)
  );

`ifdef MEM_DADOS_CLEAR_EN
  clr_state_t       r_state;
  clr_state_t       w_state_nx;
  logic [IDX_W-1:0] r_clr_cnt;
  logic [IDX_W-1:0] w_clr_cnt_nx;

  // Clear sequencer state register; reset restarts the sweep at word 0.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= ST_CLEAR;
      r_clr_cnt <= '0;
    end else begin
      r_state   <= w_state_nx;
      r_clr_cnt <= w_clr_cnt_nx;
    end
  end

  // Sweep one word per cycle while clearing; accept requests only when idle.
  always_comb begin
    w_state_nx   = r_state;
    w_clr_cnt_nx = r_clr_cnt;
    w_clr_we     = 1'b0;
    w_ready      = 1'b0;
    case (r_state)
      ST_CLEAR: begin
        w_clr_we     = 1'b1;
        w_clr_cnt_nx = r_clr_cnt + 1'b1;
        if (r_clr_cnt == IDX_W'(DEPTH - 1)) w_state_nx = ST_IDLE;
      end
      ST_IDLE: w_ready = 1'b1;
    endcase
  end

  assign w_clr_idx = r_clr_cnt;
`else
  assign w_ready   = 1'b1;
  assign w_clr_we  = 1'b0;
  assign w_clr_idx = '0;
`endif

  // Array writes: clear sweep or masked store; nothing is written while rst is high.
  always_ff @(posedge clk) begin
    if (!rst) begin
      if (w_clr_we) begin
        r_mem[w_clr_idx] <= '0;
      end else if (w_is_store && !w_mis && !w_rng) begin
        for (int unsigned b = 0; b < 4; b++) begin
          if (w_mask[b]) r_mem[w_idx][8*b +: 8] <= w_wdata_rep[8*b +: 8];
        end
      end
    end
  end

  // Response registers: one-cycle pulses, rdata held until the next accepted load.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_rdata  <= '0;
      r_rvalid <= 1'b0;
      r_mis    <= 1'b0;
      r_rng    <= 1'b0;
    end else begin
      r_rvalid <= w_is_load;
      r_mis    <= w_accept & w_mis;
      r_rng    <= w_accept & w_rng;
      if (w_is_load) r_rdata <= (w_mis | w_rng) ? '0 : w_ld_data;
    end
  end

  assign bus.req_ready    = w_ready;
  assign bus.rdata        = r_rdata;
  assign bus.rvalid       = r_rvalid;
  assign bus.misalign_err = r_mis;
  assign bus.range_err    = r_rng;

endmodule
